mem_ctrl_arbiter: RTL and testbench

MEM_CTRL_ARBITER -- requirements
Module: mem_ctrl_arbiter

---
 rtl/mem_ctrl_arbiter_if.sv | 49 ++++
 rtl/mem_ctrl_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_ctrl_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and the single-port main-memory array.
// slave = arbiter side, master = caches plus memory array side.
interface mem_ctrl_arbiter_if #(
    parameter int BLOCK_ADDR_WIDTH = 29,
    parameter int BLOCK_DATA_WIDTH = 64
);
    logic                        icache_req_valid;
    logic                        icache_req_type;
    logic [BLOCK_ADDR_WIDTH-1:0] icache_req_block_addr;
    logic [BLOCK_DATA_WIDTH-1:0] icache_req_block_data;
    logic                        icache_req_ready;

    logic                        dcache_req_valid;
    logic                        dcache_req_type;
    logic [BLOCK_ADDR_WIDTH-1:0] dcache_req_block_addr;
    logic [BLOCK_DATA_WIDTH-1:0] dcache_req_block_data;
    logic                        dcache_req_ready;

    logic                        icache_resp_valid;
    logic                        dcache_resp_valid;
    logic [BLOCK_DATA_WIDTH-1:0] icache_resp_block_data;
    logic [BLOCK_DATA_WIDTH-1:0] dcache_resp_block_data;

    logic                        mem_en;
    logic                        mem_we;
    logic [BLOCK_ADDR_WIDTH-1:0] mem_addr;
    logic [BLOCK_DATA_WIDTH-1:0] mem_wdata;
    logic [BLOCK_DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  icache_req_valid, icache_req_type, icache_req_block_addr, icache_req_block_data,
        input  dcache_req_valid, dcache_req_type, dcache_req_block_addr, dcache_req_block_data,
        input  mem_rdata,
        output icache_req_ready, dcache_req_ready,
        output icache_resp_valid, dcache_resp_valid,
        output icache_resp_block_data, dcache_resp_block_data,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output icache_req_valid, icache_req_type, icache_req_block_addr, icache_req_block_data,
        output dcache_req_valid, dcache_req_type, dcache_req_block_addr, dcache_req_block_data,
        output mem_rdata,
        input  icache_req_ready, dcache_req_ready,
        input  icache_resp_valid, dcache_resp_valid,
        input  icache_resp_block_data, dcache_resp_block_data,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_ctrl_arbiter.sv
// Two-cache arbiter in front of a single-port synchronous memory array, one request in flight.
// Define MEM_CTRL_ARBITER_RR_EN for round-robin arbitration instead of strict icache priority.
module mem_ctrl_arbiter #(
    parameter int MEM_LATENCY      = 10,
    parameter int BLOCK_ADDR_WIDTH = 29,
    parameter int BLOCK_DATA_WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst_aH,
    mem_ctrl_arbiter_if.slave  bus
);
    if (MEM_LATENCY < 2 || MEM_LATENCY > 255) begin : g_latency_check
        $error("mem_ctrl_arbiter: MEM_LATENCY must be in 2..255");
    end

    localparam logic [7:0] CNT_LOAD = 8'(MEM_LATENCY - 2);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                      r_state;
    logic [7:0]                  r_cnt;
    logic                        r_grant_d;
    logic                        r_type;
    logic [BLOCK_ADDR_WIDTH-1:0] r_addr;
    logic [BLOCK_DATA_WIDTH-1:0] r_wdata;
    logic                        r_mem_en;
    logic                        r_resp_i;
    logic                        r_resp_d;

    logic                        w_idle;
    logic                        w_i_ready;
    logic                        w_d_ready;
    logic                        w_i_acc;
    logic                        w_d_acc;
    logic [BLOCK_DATA_WIDTH-1:0] w_resp_data;

    assign w_idle = (r_state == IDLE);

`ifdef MEM_CTRL_ARBITER_RR_EN
    logic r_last_grant_d;

    // Whoever was served last yields when both caches are asking.
    assign w_i_ready = w_idle & (~bus.dcache_req_valid | r_last_grant_d);
    assign w_d_ready = w_idle & (~bus.icache_req_valid | ~r_last_grant_d);

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            r_last_grant_d <= 1'b1;
        end else if (w_i_acc | w_d_acc) begin
            r_last_grant_d <= w_d_acc;
        end
    end
`else
    assign w_i_ready = w_idle;
    assign w_d_ready = w_idle & ~bus.icache_req_valid;
`endif

    assign w_i_acc = bus.icache_req_valid & w_i_ready;
    assign w_d_acc = bus.dcache_req_valid & w_d_ready;

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_grant_d <= 1'b0;
            r_type    <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_mem_en  <= 1'b0;
            r_resp_i  <= 1'b0;
            r_resp_d  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_i_acc | w_d_acc) begin
                        r_grant_d <= w_d_acc;
                        r_type    <= w_d_acc ? bus.dcache_req_type       : bus.icache_req_type;
                        r_addr    <= w_d_acc ? bus.dcache_req_block_addr : bus.icache_req_block_addr;
                        r_wdata   <= w_d_acc ? bus.dcache_req_block_data : bus.icache_req_block_data;
                        r_cnt     <= CNT_LOAD;
                        // With MEM_LATENCY==2 the array access is the very next cycle.
                        r_mem_en  <= (CNT_LOAD == 8'd0);
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == 8'd0) begin
                        r_mem_en <= 1'b0;
                        r_resp_i <= ~r_grant_d;
                        r_resp_d <= r_grant_d;
                        r_state  <= RESP;
                    end else begin
                        r_cnt    <= r_cnt - 8'd1;
                        r_mem_en <= (r_cnt == 8'd1);
                    end
                end
                RESP: begin
                    r_resp_i <= 1'b0;
                    r_resp_d <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_mem_en <= 1'b0;
                    r_resp_i <= 1'b0;
                    r_resp_d <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.icache_req_ready = w_i_ready;
    assign bus.dcache_req_ready = w_d_ready;

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_en & r_type;
    assign bus.mem_addr  = r_mem_en ? r_addr  : '0;
    assign bus.mem_wdata = r_mem_en ? r_wdata : '0;

    // Read data arrives from the array in the RESP cycle itself, so it is passed straight through.
    assign w_resp_data = r_type ? r_wdata : bus.mem_rdata;

    assign bus.icache_resp_valid      = r_resp_i;
    assign bus.dcache_resp_valid      = r_resp_d;
    assign bus.icache_resp_block_data = r_resp_i ? w_resp_data : '0;
    assign bus.dcache_resp_block_data = r_resp_d ? w_resp_data : '0;
endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Bench for mem_ctrl_arbiter: a latency-10 instance driven by a vector table and corner sequences,
// plus a latency-2 instance for back-to-back traffic.
module tb_mem_ctrl_arbiter;
    localparam int LA = 10;

    logic clk;
    logic rst_aH;
    logic load_mem;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_ctrl_arbiter_if #(.BLOCK_ADDR_WIDTH(29), .BLOCK_DATA_WIDTH(64)) busA ();
    mem_ctrl_arbiter_if #(.BLOCK_ADDR_WIDTH(29), .BLOCK_DATA_WIDTH(64)) busB ();

    mem_ctrl_arbiter #(.MEM_LATENCY(LA), .BLOCK_ADDR_WIDTH(29), .BLOCK_DATA_WIDTH(64)) dutA (
        .clk(clk), .rst_aH(rst_aH), .bus(busA.slave)
    );
    mem_ctrl_arbiter #(.MEM_LATENCY(2), .BLOCK_ADDR_WIDTH(29), .BLOCK_DATA_WIDTH(64)) dutB (
        .clk(clk), .rst_aH(rst_aH), .bus(busB.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] memA [256];
    logic [63:0] memB [256];

    function automatic logic [63:0] init_val(input int i);
        if (i == 16) return 64'hDEADBEEF_CAFEF00D;
        return {56'hA5A5A5A5A5A5A5, 8'(i)};
    endfunction

    // Synchronous single-port array models: read data one cycle after a read enable.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) begin
                memA[i] <= init_val(i);
                memB[i] <= init_val(i);
            end
        end else begin
            if (busA.mem_en) begin
                if (busA.mem_we) memA[busA.mem_addr[7:0]] <= busA.mem_wdata;
                else             busA.mem_rdata <= memA[busA.mem_addr[7:0]];
            end
            if (busB.mem_en) begin
                if (busB.mem_we) memB[busB.mem_addr[7:0]] <= busB.mem_wdata;
                else             busB.mem_rdata <= memB[busB.mem_addr[7:0]];
            end
        end
    end

    typedef struct {
        logic        is_d;
        logic        typ;
        logic [28:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drop_all();
        busA.icache_req_valid = 1'b0;
        busA.dcache_req_valid = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        logic acc;
        @(posedge clk); #1;
        if (v.is_d) begin
            busA.dcache_req_valid = 1'b1; busA.dcache_req_type = v.typ;
            busA.dcache_req_block_addr = v.addr; busA.dcache_req_block_data = v.wdata;
        end else begin
            busA.icache_req_valid = 1'b1; busA.icache_req_type = v.typ;
            busA.icache_req_block_addr = v.addr; busA.icache_req_block_data = v.wdata;
        end
        acc = 1'b0;
        for (int w = 0; w < 40 && !acc; w++) begin
            @(negedge clk);
            acc = v.is_d ? busA.dcache_req_ready : busA.icache_req_ready;
            if (!acc) begin @(posedge clk); #1; end
        end
        chk("accept_wait", 64'(acc), 64'd1);
        if (!acc) begin drop_all(); return; end
        @(posedge clk); #1;
        drop_all();
        for (int k = 1; k <= LA + 1; k++) begin
            @(negedge clk);
            if (k <= LA) chk("busy_ready", 64'({busA.icache_req_ready, busA.dcache_req_ready}), 64'd0);
            else         chk("ready_back", 64'(busA.icache_req_ready), 64'd1);
            chk("mem_en", 64'(busA.mem_en), 64'(k == LA - 1));
            if (k == LA - 1) begin
                chk("mem_we", 64'(busA.mem_we), 64'(v.typ));
                chk("mem_addr", 64'(busA.mem_addr), 64'(v.addr));
                if (v.typ) chk("mem_wdata", busA.mem_wdata, v.wdata);
            end
            chk("resp_i", 64'(busA.icache_resp_valid), 64'(k == LA && !v.is_d));
            chk("resp_d", 64'(busA.dcache_resp_valid), 64'(k == LA && v.is_d));
            chk("resp_i_data", busA.icache_resp_block_data, (k == LA && !v.is_d) ? v.exp : 64'd0);
            chk("resp_d_data", busA.dcache_resp_block_data, (k == LA && v.is_d) ? v.exp : 64'd0);
            if (k <= LA) @(posedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        int cnt_en;
        int cnt_resp;
        logic acc;

        vecs[0] = '{is_d: 1'b0, typ: 1'b0, addr: 29'h10, wdata: 64'h0, exp: 64'hDEADBEEF_CAFEF00D};
        vecs[1] = '{is_d: 1'b1, typ: 1'b1, addr: 29'h20, wdata: 64'h01234567_89ABCDEF, exp: 64'h01234567_89ABCDEF};
        vecs[2] = '{is_d: 1'b1, typ: 1'b0, addr: 29'h20, wdata: 64'h0, exp: 64'h01234567_89ABCDEF};
        vecs[3] = '{is_d: 1'b0, typ: 1'b1, addr: 29'h40, wdata: 64'h11112222_33334444, exp: 64'h11112222_33334444};
        vecs[4] = '{is_d: 1'b1, typ: 1'b0, addr: 29'h40, wdata: 64'h0, exp: 64'h11112222_33334444};
        vecs[5] = '{is_d: 1'b0, typ: 1'b0, addr: 29'h55, wdata: 64'h0, exp: 64'hA5A5A5A5_A5A5A555};

        busA.icache_req_valid = 0; busA.icache_req_type = 0; busA.icache_req_block_addr = '0; busA.icache_req_block_data = '0;
        busA.dcache_req_valid = 0; busA.dcache_req_type = 0; busA.dcache_req_block_addr = '0; busA.dcache_req_block_data = '0;
        busB.icache_req_valid = 0; busB.icache_req_type = 0; busB.icache_req_block_addr = '0; busB.icache_req_block_data = '0;
        busB.dcache_req_valid = 0; busB.dcache_req_type = 0; busB.dcache_req_block_addr = '0; busB.dcache_req_block_data = '0;
        rst_aH = 1'b1;
        load_mem = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1 load_mem = 1'b0;
        @(negedge clk);
        chk("rst_mem_en", 64'(busA.mem_en), 64'd0);
        chk("rst_mem_we", 64'(busA.mem_we), 64'd0);
        chk("rst_mem_addr", 64'(busA.mem_addr), 64'd0);
        chk("rst_mem_wdata", busA.mem_wdata, 64'd0);
        chk("rst_resp_valid", 64'({busA.icache_resp_valid, busA.dcache_resp_valid}), 64'd0);
        chk("rst_resp_i_data", busA.icache_resp_block_data, 64'd0);
        chk("rst_resp_d_data", busA.dcache_resp_block_data, 64'd0);
        @(posedge clk); #1 rst_aH = 1'b0;
        @(negedge clk);
        chk("post_rst_i_ready", 64'(busA.icache_req_ready), 64'd1);
        chk("post_rst_d_ready", 64'(busA.dcache_req_ready), 64'd1);

        // Table of single transactions
        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

`ifndef MEM_CTRL_ARBITER_RR_EN
        // Simultaneous requests: icache wins, dcache waits its turn
        @(posedge clk); #1;
        busA.icache_req_valid = 1; busA.icache_req_type = 0; busA.icache_req_block_addr = 29'h10;
        busA.dcache_req_valid = 1; busA.dcache_req_type = 0; busA.dcache_req_block_addr = 29'h20;
        @(negedge clk);
        chk("prio_i_ready", 64'(busA.icache_req_ready), 64'd1);
        chk("prio_d_ready", 64'(busA.dcache_req_ready), 64'd0);
        @(posedge clk); #1 busA.icache_req_valid = 0;
        n = 0; acc = 0;
        for (int w = 1; w <= 40 && !acc; w++) begin
            @(negedge clk);
            if (busA.mem_en) chk("prio_mem_addr", 64'(busA.mem_addr), 64'h10);
            if (busA.dcache_req_ready) begin acc = 1; n = w; end
            else begin @(posedge clk); #1; end
        end
        chk("prio_d_accept_cycle", 64'(n), 64'd11);
        @(posedge clk); #1 busA.dcache_req_valid = 0;
        m = 0; acc = 0;
        for (int w = 1; w <= 20 && !acc; w++) begin
            @(negedge clk);
            if (busA.dcache_resp_valid) begin
                acc = 1; m = w;
                chk("prio_d_data", busA.dcache_resp_block_data, 64'h01234567_89ABCDEF);
            end else begin @(posedge clk); #1; end
        end
        chk("prio_d_resp_cycle", 64'(m), 64'd10);
        @(posedge clk); #1;
`endif

        // dcache waits through a busy period and withdraws just as ready returns
        @(posedge clk); #1;
        busA.icache_req_valid = 1; busA.icache_req_type = 0; busA.icache_req_block_addr = 29'h55;
        @(negedge clk);
        chk("stale_i_ready", 64'(busA.icache_req_ready), 64'd1);
        @(posedge clk); #1;
        busA.icache_req_valid = 0;
        busA.dcache_req_valid = 1; busA.dcache_req_type = 1;
        busA.dcache_req_block_addr = 29'h60; busA.dcache_req_block_data = 64'hBAD0BAD0_BAD0BAD0;
        cnt_en = 0; cnt_resp = 0;
        for (int k = 1; k <= LA + 12; k++) begin
            @(negedge clk);
            cnt_en   += int'(busA.mem_en);
            cnt_resp += int'(busA.dcache_resp_valid);
            @(posedge clk); #1;
            if (k == LA) busA.dcache_req_valid = 0;
        end
        chk("stale_mem_en_count", 64'(cnt_en), 64'd1);
        chk("stale_d_resp_count", 64'(cnt_resp), 64'd0);
        chk("stale_mem_untouched", memA[8'h60], 64'hA5A5A5A5_A5A5A560);

        // Reset in the middle of a write
        busA.dcache_req_valid = 1; busA.dcache_req_type = 1;
        busA.dcache_req_block_addr = 29'h30; busA.dcache_req_block_data = 64'hFFFF0000_FFFF0000;
        @(negedge clk);
        chk("rst_wr_d_ready", 64'(busA.dcache_req_ready), 64'd1);
        @(posedge clk); #1 busA.dcache_req_valid = 0;
        repeat (4) @(posedge clk);
        #1 rst_aH = 1'b1;
        @(negedge clk);
        chk("mid_rst_i_ready", 64'(busA.icache_req_ready), 64'd1);
        @(posedge clk); #1 rst_aH = 1'b0;
        cnt_en = 0; cnt_resp = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            cnt_en   += int'(busA.mem_en);
            cnt_resp += int'(busA.dcache_resp_valid) + int'(busA.icache_resp_valid);
        end
        chk("rst_wr_mem_en_count", 64'(cnt_en), 64'd0);
        chk("rst_wr_resp_count", 64'(cnt_resp), 64'd0);
        chk("rst_wr_mem_untouched", memA[8'h30], 64'hA5A5A5A5_A5A5A530);

`ifdef MEM_CTRL_ARBITER_RR_EN
        // Both caches keep requesting: grants alternate starting with icache
        begin
            logic [3:0] seq;
            int nr;
            seq = '0; nr = 0;
            @(posedge clk); #1;
            busA.icache_req_valid = 1; busA.icache_req_type = 0; busA.icache_req_block_addr = 29'h10;
            busA.dcache_req_valid = 1; busA.dcache_req_type = 0; busA.dcache_req_block_addr = 29'h20;
            for (int w = 0; w < 80 && nr < 4; w++) begin
                @(negedge clk);
                if (busA.icache_resp_valid || busA.dcache_resp_valid) begin
                    seq[nr] = busA.dcache_resp_valid;
                    nr++;
                end
            end
            drop_all();
            chk("rr_resp_count", 64'(nr), 64'd4);
            chk("rr_grant_order", 64'(seq), 64'b1010);
            repeat (LA + 2) @(posedge clk);
        end
`endif

        // Latency-2 instance with back-to-back icache reads
        @(posedge clk); #1;
        busB.icache_req_valid = 1; busB.icache_req_type = 0; busB.icache_req_block_addr = 29'h10;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            chk("l2_ready", 64'(busB.icache_req_ready), 64'd1);
            @(posedge clk); #1;
            if (r == 1) busB.icache_req_valid = 0;
            @(negedge clk);
            chk("l2_mem_en_t1", 64'(busB.mem_en), 64'd1);
            chk("l2_ready_t1", 64'(busB.icache_req_ready), 64'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("l2_mem_en_t2", 64'(busB.mem_en), 64'd0);
            chk("l2_resp_t2", 64'(busB.icache_resp_valid), 64'd1);
            chk("l2_data_t2", busB.icache_resp_block_data, 64'hDEADBEEF_CAFEF00D);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("l2_ready_end", 64'(busB.icache_req_ready), 64'd1);
        chk("l2_resp_end", 64'(busB.icache_resp_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
